// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file geometry and forwarding codes for the issue/bypass logic.
package reg_scoreboard_pkg;

   localparam int REG_NUM  = 32;
   localparam int REG_SIZE = 5;

   typedef logic [REG_SIZE-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      FORWARD_NONE = 2'b00,
      FORWARD_MEM  = 2'b01,
      FORWARD_WB   = 2'b10
   } forward_e;

endpackage

// File: rtl/reg_scoreboard_busy_check.sv
// Busy test for one register index against the pending vector.
module sb_busy_check
   import reg_scoreboard_pkg::*;
(
   input  logic [REG_SIZE-1:0] idx_i,
   input  logic [REG_NUM-1:0]  pend_i,
   input  logic                wb_valid_i,
   input  logic [REG_SIZE-1:0] wb_addr_i,
   output logic                busy_o
);

   // A register completing this cycle is forwarded from W, so not busy.
   assign busy_o = (idx_i != '0) & pend_i[idx_i]
                 & !(wb_valid_i & (wb_addr_i == idx_i));

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for long-latency units: RAW/WAW/limit
// stalls at D, clearing at writeback, sticky protocol error flag.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issueValidD,
   input  logic                longOpD,
   input  logic                use1D,
   input  logic                use2D,
   input  logic [REG_SIZE-1:0] raddr1D,
   input  logic [REG_SIZE-1:0] raddr2D,
   input  logic                regWriteD,
   input  logic [REG_SIZE-1:0] writeRegD,
   input  logic                flushD,
   input  logic                wbValid,
   input  logic [REG_SIZE-1:0] wbAddr,
   output logic                stallD,
   output logic                flushE,
   output logic [REG_NUM-1:0]  pending,
   output logic [CNT_W-1:0]    outstanding,
   output logic                sbError
);

   logic [REG_NUM-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               busy1, busy2, busy_rd;
   logic               wb_eff, full, valid_d, hz, issue;
   logic               wb_stray, overflow;

   sb_busy_check u_rs1 (
      .idx_i      (raddr1D),
      .pend_i     (pending_q),
      .wb_valid_i (wbValid),
      .wb_addr_i  (wbAddr),
      .busy_o     (busy1)
   );

   sb_busy_check u_rs2 (
      .idx_i      (raddr2D),
      .pend_i     (pending_q),
      .wb_valid_i (wbValid),
      .wb_addr_i  (wbAddr),
      .busy_o     (busy2)
   );

   sb_busy_check u_rd (
      .idx_i      (writeRegD),
      .pend_i     (pending_q),
      .wb_valid_i (wbValid),
      .wb_addr_i  (wbAddr),
      .busy_o     (busy_rd)
   );

   assign wb_eff   = wbValid & (wbAddr != '0) & pending_q[wbAddr];
   assign wb_stray = wbValid & (wbAddr != '0) & !pending_q[wbAddr];
   assign full     = (cnt_q == CNT_W'(MAX_OUTSTANDING)) & !wb_eff;
   assign valid_d  = issueValidD & !flushD;

   assign hz = valid_d & ((use1D & busy1) | (use2D & busy2)
             | (regWriteD & busy_rd) | (longOpD & regWriteD & full));

   assign issue = valid_d & !hz & longOpD & regWriteD
                & (writeRegD != '0);

   // Only reachable if the limit stall above is broken.
   assign overflow = issue & !wb_eff
                   & (cnt_q == CNT_W'(MAX_OUTSTANDING));

   always_comb begin
      pending_d = pending_q;
      if (wb_eff) pending_d[wbAddr] = 1'b0;
      if (issue)  pending_d[writeRegD] = 1'b1;
      pending_d[0] = 1'b0;
      cnt_d = cnt_q + CNT_W'(issue) - CNT_W'(wb_eff);
      err_d = err_q | wb_stray | overflow;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   assign stallD      = hz;
   assign flushE      = hz;
   assign pending     = pending_q;
   assign outstanding = cnt_q;
   assign sbError     = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: reference model predicts stall and next state per cycle.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issueValidD, longOpD, use1D, use2D;
   logic [4:0]  raddr1D, raddr2D, writeRegD, wbAddr;
   logic        regWriteD, flushD, wbValid;
   logic        stallD, flushE, sbError;
   logic [31:0] pending;
   logic [2:0]  outstanding;

   typedef struct {
      logic [31:0] p;
      logic [2:0]  o;
      logic        e;
   } st_t;

   logic exp_hz_q[$];
   st_t  exp_st_q[$];

   logic [31:0] m_pend;
   logic [2:0]  m_cnt;
   logic        m_err;

   int n_checks = 0;
   int n_errors = 0;

   reg_scoreboard dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issueValidD (issueValidD),
      .longOpD     (longOpD),
      .use1D       (use1D),
      .use2D       (use2D),
      .raddr1D     (raddr1D),
      .raddr2D     (raddr2D),
      .regWriteD   (regWriteD),
      .writeRegD   (writeRegD),
      .flushD      (flushD),
      .wbValid     (wbValid),
      .wbAddr      (wbAddr),
      .stallD      (stallD),
      .flushE      (flushE),
      .pending     (pending),
      .outstanding (outstanding),
      .sbError     (sbError)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic m_busy(input logic [4:0] r,
                                   input logic wv, input logic [4:0] wa);
      return (r != 0) && m_pend[r] && !(wv && wa == r);
   endfunction

   // Called at posedge+1; drives one D/W cycle and checks it.
   task automatic cyc(input logic iv, input logic lo,
                      input logic u1, input logic [4:0] r1,
                      input logic u2, input logic [4:0] r2,
                      input logic rw, input logic [4:0] wr,
                      input logic fl, input logic wv,
                      input logic [4:0] wa);
      logic hz, full, weff, iss;
      st_t  s;
      issueValidD = iv; longOpD = lo;
      use1D = u1; raddr1D = r1; use2D = u2; raddr2D = r2;
      regWriteD = rw; writeRegD = wr; flushD = fl;
      wbValid = wv; wbAddr = wa;
      weff = wv && wa != 0 && m_pend[wa];
      full = (m_cnt == 3'd4) && !weff;
      hz = iv && !fl && ((u1 && m_busy(r1, wv, wa))
         || (u2 && m_busy(r2, wv, wa)) || (rw && m_busy(wr, wv, wa))
         || (lo && rw && full));
      iss = iv && !fl && !hz && lo && rw && wr != 0;
      exp_hz_q.push_back(hz);
      s.p = m_pend;
      if (weff) s.p[wa] = 1'b0;
      if (iss)  s.p[wr] = 1'b1;
      s.o = m_cnt + 3'(iss) - 3'(weff);
      s.e = m_err || (wv && wa != 0 && !m_pend[wa])
          || (iss && !weff && m_cnt == 3'd4);
      exp_st_q.push_back(s);
      @(negedge clk);
      hz = exp_hz_q.pop_front();
      chk("stallD", 32'(stallD), 32'(hz));
      chk("flushE", 32'(flushE), 32'(hz));
      @(posedge clk);
      #1;
      s = exp_st_q.pop_front();
      m_pend = s.p; m_cnt = s.o; m_err = s.e;
      chk("pending", pending, s.p);
      chk("outstanding", 32'(outstanding), 32'(s.o));
      chk("sbError", 32'(sbError), 32'(s.e));
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic long_op(input logic [4:0] rd);
      cyc(1, 1, 0, 0, 0, 0, 1, rd, 0, 0, 0);
   endtask

   task automatic wb(input logic [4:0] a);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, a);
   endtask

   // Async reset asserted between clock edges.
   task automatic do_reset();
      issueValidD = 0; longOpD = 0; use1D = 0; use2D = 0;
      raddr1D = 0; raddr2D = 0; regWriteD = 0; writeRegD = 0;
      flushD = 0; wbValid = 0; wbAddr = 0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      m_pend = '0; m_cnt = '0; m_err = 1'b0;
      chk("rst_pending", pending, 32'h0);
      chk("rst_outstanding", 32'(outstanding), 32'h0);
      chk("rst_sbError", 32'(sbError), 32'h0);
      chk("rst_stallD", 32'(stallD), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      m_pend = '0; m_cnt = '0; m_err = 1'b0;
      issueValidD = 0; longOpD = 0; use1D = 0; use2D = 0;
      raddr1D = 0; raddr2D = 0; regWriteD = 0; writeRegD = 0;
      flushD = 0; wbValid = 0; wbAddr = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle();

      // RAW on rd=5
      long_op(5);
      cyc(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 5, 0, 0, 0, 0, 0, 1, 5);

      // WAW and same-cycle writeback on rd=7
      long_op(7);
      cyc(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 1, 7, 0, 1, 7);
      wb(7);

      // Reset mid-operation with entries pending
      long_op(8);
      long_op(10);
      do_reset();
      idle();

      // Outstanding limit
      long_op(1); long_op(2); long_op(3); long_op(4);
      long_op(9);
      cyc(1, 1, 0, 0, 0, 0, 1, 9, 0, 1, 2);
      wb(1); wb(3); wb(4); wb(9);

      // x0 and flushD
      long_op(0);
      cyc(1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
      long_op(11);
      cyc(1, 0, 0, 0, 1, 11, 0, 0, 1, 0, 0);
      wb(0);
      wb(11);

      // Stray writeback sets sticky error
      wb(6);
      idle(); idle();
      do_reset();
      idle();

      // Randomised traffic over a small register window
      for (int i = 0; i < 80; i++) begin
         logic [4:0] w;
         w = 5'($urandom_range(0, 7));
         if (w != 0 && !m_pend[w]) w = 0;
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 2) == 0), w);
      end

      if (exp_hz_q.size() != 0 || exp_st_q.size() != 0) begin
         n_errors++;
         $display("FAIL queue_drain: %0d left, 0 expected",
                  exp_hz_q.size() + exp_st_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: run still active, finish expected");
      $fatal(1);
   end

endmodule
